// File: rtl/kyber_step_seq_pkg.sv
// kyber_seq_pkg: shared constants and types for the Kyber step sequencer.
//   NSTEP   schedule length / mask width
//   IW      step-index width
//   state_t sequencer FSM states
//   K2..K4  legal module ranks
package kyber_seq_pkg;

    localparam int unsigned NSTEP = 73;
    localparam int unsigned IW    = 7;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT,
        FIN
    } state_t;

    localparam logic [2:0] K2 = 3'd2;
    localparam logic [2:0] K3 = 3'd3;
    localparam logic [2:0] K4 = 3'd4;

    function automatic logic k_legal(input logic [2:0] k);
        return (k == K2) || (k == K3) || (k == K4);
    endfunction

endpackage

// File: rtl/kyber_step_seq_if.sv
// kyber_step_seq_if: control and shared-unit handshake bundle of the sequencer.
//   caller side : start, abort, k, sel, patt, eta3, endp -> busy, done, err
//   unit side   : op_done -> op_start, op_eta3, op_idx
//   modport master drives the requests, modport slave is the sequencer.
interface kyber_step_seq_if;
    import kyber_seq_pkg::*;

    logic             start;
    logic             abort;
    logic [2:0]       k;
    logic             sel;
    logic [NSTEP-1:0] patt;
    logic [NSTEP-1:0] eta3;
    logic [NSTEP-1:0] endp;
    logic             op_done;
    logic             op_start;
    logic             op_eta3;
    logic [IW-1:0]    op_idx;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, abort, k, sel, patt, eta3, endp, op_done,
        input  op_start, op_eta3, op_idx, busy, done, err
    );

    modport slave (
        input  start, abort, k, sel, patt, eta3, endp, op_done,
        output op_start, op_eta3, op_idx, busy, done, err
    );

endinterface

// File: rtl/kyber_step_shreg.sv
// kyber_step_shreg: issue/eta3/end mask registers (parallel load, shift left)
// plus the step counter. Step 0 lives in the MSB, so the head bit is always
// bit NSTEP-1.
//   clk, rst_n          clock, synchronous active-low reset
//   load                capture the masks and clear the step counter
//   shift               advance to the next step
//   patt_in/eta3_in/endp_in  masks to capture
//   head_patt/head_eta3 head bits of the current step
//   head_end            end mark of the current step (forced on the last index)
//   step                current step index
module kyber_step_shreg
    import kyber_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [NSTEP-1:0] patt_in,
    input  logic [NSTEP-1:0] eta3_in,
    input  logic [NSTEP-1:0] endp_in,
    output logic             head_patt,
    output logic             head_eta3,
    output logic             head_end,
    output logic [IW-1:0]    step
);

    logic [NSTEP-1:0] patt_q;
    logic [NSTEP-1:0] eta3_q;
    logic [NSTEP-1:0] endp_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            patt_q <= '0;
            eta3_q <= '0;
            endp_q <= '0;
            step   <= '0;
        end else if (load) begin
            patt_q <= patt_in;
            eta3_q <= eta3_in;
            endp_q <= endp_in;
            step   <= '0;
        end else if (shift) begin
            patt_q <= {patt_q[NSTEP-2:0], 1'b0};
            eta3_q <= {eta3_q[NSTEP-2:0], 1'b0};
            endp_q <= {endp_q[NSTEP-2:0], 1'b0};
            step   <= step + IW'(1);
        end
    end

    assign head_patt = patt_q[NSTEP-1];
    assign head_eta3 = eta3_q[NSTEP-1];
    // The last index always terminates so the counter can never wrap.
    assign head_end  = endp_q[NSTEP-1] | (step == IW'(NSTEP - 1));

endmodule

// File: rtl/kyber_step_seq.sv
// kyber_step_seq: walks a latched 73-step schedule, issuing one-cycle start
// commands to the shared sampling/polynomial unit for each marked step and
// waiting for its completion before moving on.
//   clk, rst_n  clock, synchronous active-low reset
//   bus         kyber_step_seq_if.slave: start/abort/k/sel/masks/op_done in,
//               op_start/op_eta3/op_idx/busy/done/err out
// All outputs are decoded from registered state; nothing combinational from
// the inputs reaches an output.
module kyber_step_seq
    import kyber_seq_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    kyber_step_seq_if.slave bus
);

    state_t        state;
    state_t        state_nx;
    logic          load;
    logic          shift;
    logic          err_q;
    logic          head_patt;
    logic          head_eta3;
    logic          head_end;
    logic [IW-1:0] step;

    kyber_step_shreg u_shreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .shift     (shift),
        .patt_in   (bus.patt),
        .eta3_in   (bus.eta3),
        .endp_in   (bus.endp),
        .head_patt (head_patt),
        .head_eta3 (head_eta3),
        .head_end  (head_end),
        .step      (step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= (state == IDLE) && bus.start && !k_legal(bus.k) && !bus.abort;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        shift    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && k_legal(bus.k)) begin
                    load     = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (head_patt) begin
                    state_nx = ISSUE;
                end else if (head_end) begin
                    state_nx = FIN;
                end else begin
                    shift = 1'b1;
                end
            end
            ISSUE: state_nx = WAIT;
            WAIT: begin
                if (bus.op_done) begin
                    if (head_end) begin
                        state_nx = FIN;
                    end else begin
                        shift    = 1'b1;
                        state_nx = SCAN;
                    end
                end
            end
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort overrides everything, including a load or shift decided above.
        if (bus.abort) begin
            state_nx = IDLE;
            load     = 1'b0;
            shift    = 1'b0;
        end
    end

    assign bus.op_start = (state == ISSUE);
    assign bus.op_eta3  = (state == ISSUE) && head_eta3;
    assign bus.op_idx   = (state == ISSUE) ? step : '0;
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == FIN);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_kyber_step_seq.sv
module tb_kyber_step_seq;
    import kyber_seq_pkg::*;

    logic clk;
    logic rst_n;

    kyber_step_seq_if bus();

    kyber_step_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned idx;
        bit          eta3;
    } exp_t;

    exp_t exp_q[$];
    int   checks;
    int   errors;

    // op_done responder configuration
    int   fixed_d;
    bit   rand_d;
    bit   poke;
    int   wait_sum;
    int   resp_d;

    // Scoreboard: every op_start must match the head of the expected queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.op_start === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL op_start_unexpected: got idx=%0d eta3=%0b, required no issue",
                             bus.op_idx, bus.op_eta3);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.op_idx !== IW'(e.idx) || bus.op_eta3 !== e.eta3) begin
                        errors++;
                        $display("FAIL op_issue: got idx=%0d eta3=%0b, required idx=%0d eta3=%0b",
                                 bus.op_idx, bus.op_eta3, e.idx, e.eta3);
                    end
                end
            end
        end
    end

    // Shared-unit model: answers each op_start after resp_d WAIT cycles.
    // With poke set it also raises op_done during the ISSUE cycle itself.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.op_start === 1'b1) begin
                resp_d = rand_d ? int'($urandom_range(1, 20)) : fixed_d;
                if (poke) bus.op_done = 1'b1;
                @(negedge clk);
                bus.op_done = 1'b0;
                repeat (resp_d - 1) @(negedge clk);
                bus.op_done = 1'b1;
                @(negedge clk);
                bus.op_done = 1'b0;
                wait_sum += resp_d;
            end
        end
    end

    task automatic do_start(input logic [2:0] k, input logic sel, input logic [NSTEP-1:0] p,
                            input logic [NSTEP-1:0] e3, input logic [NSTEP-1:0] en);
        wait_sum  = 0;
        bus.k     = k;
        bus.sel   = sel;
        bus.patt  = p;
        bus.eta3  = e3;
        bus.endp  = en;
        bus.start = 1'b1;
        @(posedge clk);
    endtask

    // Counts cycles after the start edge until done; scrambles the inputs
    // right after the latch edge so only the latched copy can matter.
    task automatic wait_done(input int limit, output int n, output bit seen);
        n    = 0;
        seen = 1'b0;
        while (n < limit && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                bus.start = 1'b0;
                bus.patt  = ~bus.patt;
                bus.eta3  = ~bus.eta3;
                bus.endp  = '0;
                bus.k     = 3'd7;
                bus.sel   = ~bus.sel;
            end
            if (bus.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.op_start, bus.op_eta3, bus.busy, bus.done, bus.err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %05b, required 00000",
                     {bus.op_start, bus.op_eta3, bus.busy, bus.done, bus.err});
        end
        checks++;
        if (bus.op_idx !== '0) begin
            errors++;
            $display("FAIL reset_idx: got %0d, required 0", bus.op_idx);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_k2_sel0();
        int unsigned iss[4] = '{0, 6, 12, 18};
        logic [NSTEP-1:0] p, e3, en;
        int n;
        bit seen;
        p = '0; e3 = '0; en = '0;
        foreach (iss[i]) begin
            p[NSTEP-1-iss[i]]  = 1'b1;
            e3[NSTEP-1-iss[i]] = 1'b1;
            exp_q.push_back('{idx: iss[i], eta3: 1'b1});
        end
        en[NSTEP-1-23] = 1'b1;
        fixed_d = 1; rand_d = 0; poke = 0;
        do_start(K2, 1'b0, p, e3, en);
        wait_done(300, n, seen);
        checks++;
        if (!seen || n != 33) begin
            errors++;
            $display("FAIL k2s0_done_latency: got seen=%0b n=%0d, required n=33", seen, n);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL k2s0_after: got busy=%0b done=%0b pending=%0d, required 0 0 0",
                     bus.busy, bus.done, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_k3_random();
        int unsigned iss[6] = '{0, 5, 10, 11, 20, 33};
        logic [NSTEP-1:0] p, en;
        int n, want;
        bit seen;
        p = '0; en = '0;
        foreach (iss[i]) begin
            p[NSTEP-1-iss[i]] = 1'b1;
            exp_q.push_back('{idx: iss[i], eta3: 1'b0});
        end
        en[NSTEP-1-41] = 1'b1;
        rand_d = 1; poke = 0;
        do_start(K3, 1'b0, p, '0, en);
        wait_done(1000, n, seen);
        @(negedge clk);
        want = 41 + 2 + 6 + wait_sum;
        checks++;
        if (!seen || n != want) begin
            errors++;
            $display("FAIL k3_done_latency: got seen=%0b n=%0d, required n=%0d", seen, n, want);
        end
        checks++;
        if (bus.busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL k3_after: got busy=%0b pending=%0d, required 0 0", bus.busy, exp_q.size());
            exp_q.delete();
        end
        rand_d = 0;
    endtask

    task automatic test_k2_sel1();
        int unsigned iss[5] = '{0, 6, 16, 21, 22};
        logic [NSTEP-1:0] p, e3, en;
        int n, want;
        bit seen;
        p = '0; e3 = '0; en = '0;
        e3[NSTEP-1-0] = 1'b1;
        e3[NSTEP-1-6] = 1'b1;
        foreach (iss[i]) begin
            p[NSTEP-1-iss[i]] = 1'b1;
            exp_q.push_back('{idx: iss[i], eta3: (iss[i] == 0 || iss[i] == 6)});
        end
        en[NSTEP-1-22] = 1'b1;
        fixed_d = 1; poke = 0;
        do_start(K2, 1'b1, p, e3, en);
        wait_done(300, n, seen);
        @(negedge clk);
        want = 22 + 2 + 5 + wait_sum;
        checks++;
        if (!seen || n != want) begin
            errors++;
            $display("FAIL k2s1_done_latency: got seen=%0b n=%0d, required n=%0d", seen, n, want);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL k2s1_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_k4_poke();
        int unsigned iss[8] = '{0, 5, 10, 11, 12, 25, 42, 59};
        logic [NSTEP-1:0] p, e3, en;
        int n, want;
        bit seen;
        p = '0; e3 = '0; en = '0;
        e3[NSTEP-1-42] = 1'b1;
        foreach (iss[i]) begin
            p[NSTEP-1-iss[i]] = 1'b1;
            exp_q.push_back('{idx: iss[i], eta3: (iss[i] == 42)});
        end
        en[NSTEP-1-71] = 1'b1;
        fixed_d = 3; poke = 1;
        do_start(K4, 1'b0, p, e3, en);
        wait_done(500, n, seen);
        @(negedge clk);
        want = 71 + 2 + 8 + wait_sum;
        checks++;
        if (!seen || n != want) begin
            errors++;
            $display("FAIL k4_issue_done_ignored: got seen=%0b n=%0d, required n=%0d", seen, n, want);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL k4_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end
        poke = 0;
    endtask

    task automatic test_overrun();
        logic [NSTEP-1:0] p;
        int n, want;
        bit seen;
        p = '0;
        p[0] = 1'b1;
        exp_q.push_back('{idx: NSTEP - 1, eta3: 1'b0});
        fixed_d = 2;
        do_start(K3, 1'b0, p, '0, '0);
        wait_done(300, n, seen);
        @(negedge clk);
        want = int'(NSTEP - 1) + 2 + 1 + wait_sum;
        checks++;
        if (!seen || n != want) begin
            errors++;
            $display("FAIL overrun_guard: got seen=%0b n=%0d, required n=%0d", seen, n, want);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_pending: got %0d, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bad_k();
        bus.k     = 3'd5;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL badk_pulse: got err=%0b busy=%0b, required 1 0", bus.err, bus.busy);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL badk_after: got err=%0b busy=%0b, required 0 0", bus.err, bus.busy);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_abort();
        int unsigned iss[3] = '{0, 6, 12};
        logic [NSTEP-1:0] p, en;
        int cnt, n;
        bit done_seen;
        p = '0; en = '0;
        foreach (iss[i]) begin
            p[NSTEP-1-iss[i]] = 1'b1;
            exp_q.push_back('{idx: iss[i], eta3: 1'b0});
        end
        p[NSTEP-1-18] = 1'b1;
        en[NSTEP-1-23] = 1'b1;
        fixed_d = 5;
        do_start(K2, 1'b0, p, '0, en);
        cnt = 0; n = 0;
        while (cnt < 3 && n < 200) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            if (bus.op_start === 1'b1) cnt++;
        end
        checks++;
        if (cnt != 3) begin
            errors++;
            $display("FAIL abort_reach_issue3: got %0d issues, required 3", cnt);
        end
        @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.op_start !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%0b op_start=%0b done=%0b, required 0 0 0",
                     bus.busy, bus.op_start, bus.done);
        end
        done_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen = 1'b1;
        end
        checks++;
        if (done_seen || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort_quiet: got activity=%0b pending=%0d, required 0 0",
                     done_seen, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        logic [NSTEP-1:0] p, en;
        p = '0; en = '0;
        p[NSTEP-1-0]  = 1'b1;
        p[NSTEP-1-6]  = 1'b1;
        en[NSTEP-1-23] = 1'b1;
        exp_q.push_back('{idx: 0, eta3: 1'b0});
        fixed_d = 1;
        do_start(K2, 1'b0, p, '0, en);
        repeat (5) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.op_start, bus.op_eta3, bus.busy, bus.done, bus.err} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_flags: got %05b, required 00000",
                     {bus.op_start, bus.op_eta3, bus.busy, bus.done, bus.err});
        end
        checks++;
        if (bus.op_idx !== '0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_idx: got idx=%0d pending=%0d, required 0 0",
                     bus.op_idx, exp_q.size());
            exp_q.delete();
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        fixed_d     = 1;
        rand_d      = 0;
        poke        = 0;
        wait_sum    = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.k       = 3'd0;
        bus.sel     = 1'b0;
        bus.patt    = '0;
        bus.eta3    = '0;
        bus.endp    = '0;
        bus.op_done = 1'b0;
        @(negedge clk);
        test_reset();
        test_k2_sel0();
        test_k3_random();
        test_k2_sel1();
        test_k4_poke();
        test_overrun();
        test_bad_k();
        test_abort();
        test_reset_mid();
        test_k2_sel0();
        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/kyber_step_seq.md
# kyber_step_seq

Sequencer for the Kyber operation schedule. On `start` it latches the 73-step issue/eta3/end masks for the selected parameter set (`k`, `sel`) and walks them one step at a time. For each marked step it issues a one-cycle start command to the shared sampling/polynomial unit, waits for that unit's completion handshake, and terminates at the end-marked step. It sits between the top-level Kyber FSM and the shared arithmetic unit.

## Interface
- `NSTEP`, 73: schedule length; mask width.
- `IW`, 7: step-index width, ceil(log2(NSTEP)).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a schedule; sampled only in IDLE.
- `abort` in 1: synchronous cancel; highest priority after reset.
- `k` in 3: module rank; legal values are 2, 3, 4.
- `sel` in 1: schedule variant select.
- `patt` in NSTEP: issue mask; bit NSTEP-1 is step 0 (MSB-first).
- `eta3` in NSTEP: per-step eta=3 flag, same bit order.
- `endp` in NSTEP: end-of-schedule mask, same bit order.
- `op_done` in 1: completion pulse from the shared unit.
- `op_start` out 1: one-cycle command pulse.
- `op_eta3` out 1: eta3 flag of the issued step; valid with `op_start`.
- `op_idx` out IW: step index of the issued step; valid with `op_start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `err` out 1: one-cycle pulse when `start` arrives with an illegal `k`.

## Operation
- States: IDLE, SCAN, ISSUE, WAIT, FIN.
- IDLE:
  - `start` with `k` ∈ {2,3,4`}`: latch `patt`, `eta3`, `endp` into internal shift registers, clear `step` to 0, go to SCAN.
  - `start` with any other `k`: pulse `err`, stay in IDLE.
- SCAN examines the current head bits.
  - patt=1: go to ISSUE.
  - patt=0 and endp=1: go to FIN.
  - patt=0, endp=0: shift the masks, increment `step`, stay in SCAN.
- ISSUE: lasts exactly 1 cycle with `op_start`=1, `op_idx`=`step`, `op_eta3`=head eta3 bit. Then go to WAIT.
- WAIT: hold until `op_done`=1.
  - If endp=1: go to FIN.
  - Otherwise: shift, increment, go to SCAN.
- FIN: `done`=1 for 1 cycle, then IDLE.
- `op_done` is ignored outside WAIT, including during ISSUE.
- Overrun guard: a step with index NSTEP-1 is treated as end-marked even if its endp bit is 0, so the index never wraps.
- `abort` in any state: next state IDLE, no `done`. An outstanding operation is abandoned, and the caller owns draining the shared unit.
- Input changes on `k`, `sel` or the masks after the latch cycle have no effect.
- `start` while busy is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `op_start`, `op_eta3`, `busy`, `done`, `err` all 0.
  - `op_idx` 0.
  - Internal step counter 0.
- All outputs are registered or Moore-decoded from state. No combinational path from inputs to outputs.
- Cycle cost per step:
  - Non-issue step: 1 cycle.
  - Issue step: 2 cycles + WAIT length, where WAIT is ≥1 cycle and ends in the cycle `op_done` is seen.
- `start` sampled at edge E0 means SCAN step 0 is in the cycle after E0.
- `done` is asserted in the cycle after the end step's SCAN or WAIT.
- `busy` goes high the cycle after `start` and falls the cycle after FIN.
- Reset or `abort` mid-operation: outputs return to reset values on the next edge.

## Structure
- Package `kyber_seq_pkg` holds:
  - NSTEP, IW.
  - State enum.
  - Legal-k constants K2, K3, K4.
- One natural sub-module, `kyber_step_shreg`: the three parallel-load / shift-left mask registers plus the step counter, exposing the head bits.
- Mask generation is external; this block only consumes it.

## Test plan
- Case k=2, sel=0:
  - Masks: issue steps 0,6,12,18, all eta3=1, end at 23.
  - `op_done` returned in the first WAIT cycle.
  - Expect:
    - 4 `op_start` pulses with `op_idx` 0,6,12,18, each with `op_eta3`=1.
    - `done` 33 cycles after E0.
- Case k=3, sel=0:
  - Expect 6 issues at idx 0,5,10,11,20,33, `op_eta3`=0, end at 41.
  - Randomised `op_done` delay of 1–20 cycles must not change the issue order.
- Case k=2, sel=1:
  - Expect 5 issues at 0,6,16,21,22, with eta3=1 only at 0 and 6.
  - End coincides with issue 22: `done` the cycle after that WAIT completes.
- Case k=4, sel=0:
  - Expect 8 issues at 0,5,10,11,12,25,42,59, end at 71.
  - Additionally drive `op_done` during an ISSUE cycle: it must be ignored, and the unit stays in WAIT.
- `start` with k=5:
  - Expect `err` 1 cycle, `busy` stays 0, no `op_start`.
- Error injection:
  - `abort` in WAIT of the 3rd issue: IDLE next cycle, no `done`.
  - `rst_n`=0 mid-SCAN: all outputs at reset values after the edge.
  - Then a fresh `start` runs the full schedule correctly.
